// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Constants and types shared by the read-side and write-side controllers of
// the 16-entry FIFO.
//
// Contents:
//   PTR_W      pointer width (address bits plus one wrap bit)
//   ADDR_W     memory address width
//   DEPTH      number of entries
//   AE_LVL     default almost-empty threshold, in entries
//   AF_LVL     default almost-full threshold, in entries
//   fifo_ptr_t pointer type
//   err_mode_e behaviour of the underflow/overflow flags
//
// Optional feature macro: FIFO_STICKY_ERR_EN (consumed by fifo_err_flag).
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int PTR_W  = 5;
  localparam int ADDR_W = PTR_W - 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int AE_LVL = 2;
  localparam int AF_LVL = 14;

  typedef logic [PTR_W-1:0] fifo_ptr_t;

  // Pulse: flag is high for exactly one cycle after each event.
  // Sticky: flag sets after an event and holds until cleared.
  typedef enum logic {
    ERR_PULSE  = 1'b0,
    ERR_STICKY = 1'b1
  } err_mode_e;

  // Next pointer value; the wrap bit toggles naturally on the carry out of
  // the address bits.
  function automatic fifo_ptr_t ptr_next(input fifo_ptr_t ptr);
    return ptr + fifo_ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_err_flag.sv
// ---------------------------------------------------------------------------
// fifo_err_flag
//
// One FIFO error flag (used for both underflow and overflow). Registers the
// event and turns it into either a single-cycle pulse or a sticky flag.
//
// Configuration macro: FIFO_STICKY_ERR_EN
//   defined   : flag sets on the edge after an event and holds until err_clr;
//               an event in the same cycle as err_clr keeps the flag set.
//   undefined : flag is a registered one-cycle pulse; err_clr has no effect.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   evt      in   error event this cycle
//   err_clr  in   clear request (sticky mode only)
//   flag     out  registered error flag
//   mode     out  flag behaviour selected at build time
// ---------------------------------------------------------------------------
module fifo_err_flag
  import fifo_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      evt,
  input  logic      err_clr,
  output logic      flag,
  output err_mode_e mode
);

`ifdef FIFO_STICKY_ERR_EN
  localparam err_mode_e MODE = ERR_STICKY;
`else
  localparam err_mode_e MODE = ERR_PULSE;
`endif

  assign mode = MODE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (MODE == ERR_STICKY) begin
      // Set has priority over clear so an event coincident with err_clr
      // is never lost.
      if (evt) begin
        flag <= 1'b1;
      end else if (err_clr) begin
        flag <= 1'b0;
      end
    end else begin
      flag <= evt;
    end
  end

endmodule

// File: rtl/read_pointer_status.sv
// ---------------------------------------------------------------------------
// read_pointer_status
//
// Read-side controller of the 16-entry FIFO. Owns the read pointer, turns
// read requests into a qualified memory read enable, flags the cycle in which
// read data is valid, and derives every FIFO status signal from its own read
// pointer and the write side's registered write pointer.
//
// Parameters:
//   PTR_W   pointer width (ADDR_W = PTR_W-1 address bits plus one wrap bit)
//   AE_LVL  almost-empty threshold, in entries (level <= AE_LVL)
//   AF_LVL  almost-full threshold, in entries (level >= AF_LVL)
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   rd                 in   read request
//   wr                 in   raw write request (overflow detection only)
//   wptr               in   registered write pointer from the write side
//   err_clr            in   clears sticky error flags
//   rptr               out  registered read pointer, [ADDR_W-1:0] = address
//   fifo_re            out  qualified read enable
//   fifo_empty         out  FIFO empty
//   fifo_full_wire     out  FIFO full, fed back to the write side
//   fifo_almost_empty  out  level <= AE_LVL
//   fifo_almost_full   out  level >= AF_LVL
//   fifo_level         out  occupancy, 0..DEPTH
//   rd_valid           out  memory read data valid this cycle
//   underflow          out  read attempted while empty
//   overflow           out  write attempted while full
//
// Configuration macro: FIFO_STICKY_ERR_EN (sticky error flags, see
// fifo_err_flag). Default build gives single-cycle error pulses.
//
// Read handshake: rd is a request with no hold requirement. The read is
// accepted in the same cycle exactly when fifo_re = rd & ~fifo_empty; an
// unaccepted request is dropped, not queued, and must be re-presented by the
// requester. Data for an accepted read is valid one cycle later (rd_valid).
// ---------------------------------------------------------------------------
module read_pointer_status #(
  parameter int PTR_W  = fifo_pkg::PTR_W,
  parameter int AE_LVL = fifo_pkg::AE_LVL,
  parameter int AF_LVL = fifo_pkg::AF_LVL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd,
  input  logic             wr,
  input  logic [PTR_W-1:0] wptr,
  input  logic             err_clr,
  output logic [PTR_W-1:0] rptr,
  output logic             fifo_re,
  output logic             fifo_empty,
  output logic             fifo_full_wire,
  output logic             fifo_almost_empty,
  output logic             fifo_almost_full,
  output logic [PTR_W-1:0] fifo_level,
  output logic             rd_valid,
  output logic             underflow,
  output logic             overflow
);

  localparam int ADDR_W = PTR_W - 1;

  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LVL);
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LVL);

  logic [PTR_W-1:0] rptr_q;
  logic             rd_valid_q;
  logic             underflow_evt;
  logic             overflow_evt;

  // Flag modes are build-time constants; kept visible for debug only.
  fifo_pkg::err_mode_e unused_uf_mode;
  fifo_pkg::err_mode_e unused_of_mode;

  // -------------------------------------------------------------------------
  // Status, purely from the two registered pointers.
  // -------------------------------------------------------------------------
  // With one extra wrap bit the modulo-2^PTR_W difference is the exact
  // occupancy in 0..DEPTH, so no separate counter is needed.
  assign fifo_level = wptr - rptr_q;

  assign fifo_empty = (wptr == rptr_q);

  // Same address, opposite lap: the writer is exactly one lap ahead.
  assign fifo_full_wire = (wptr[PTR_W-1] != rptr_q[PTR_W-1]) &&
                          (wptr[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  assign fifo_almost_empty = (fifo_level <= AE_THR);
  assign fifo_almost_full  = (fifo_level >= AF_THR);

  // -------------------------------------------------------------------------
  // Read qualification.
  // -------------------------------------------------------------------------
  // A read while full is fine (it frees a slot); only empty blocks it.
  assign fifo_re = rd & ~fifo_empty;

  assign underflow_evt = rd & fifo_empty;
  assign overflow_evt  = wr & fifo_full_wire;

  // -------------------------------------------------------------------------
  // Read pointer and read-data-valid.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      // Memory output is registered, so data for this cycle's accepted read
      // appears next cycle; back-to-back reads keep rd_valid high.
      rd_valid_q <= fifo_re;
      if (fifo_re) begin
        // Natural wrap from all-ones to zero; no saturation.
        rptr_q <= rptr_q + PTR_W'(1);
      end
    end
  end

  assign rptr     = rptr_q;
  assign rd_valid = rd_valid_q;

  // -------------------------------------------------------------------------
  // Error flags.
  // -------------------------------------------------------------------------
  fifo_err_flag u_underflow (
    .clk     (clk),
    .rst_n   (rst_n),
    .evt     (underflow_evt),
    .err_clr (err_clr),
    .flag    (underflow),
    .mode    (unused_uf_mode)
  );

  fifo_err_flag u_overflow (
    .clk     (clk),
    .rst_n   (rst_n),
    .evt     (overflow_evt),
    .err_clr (err_clr),
    .flag    (overflow),
    .mode    (unused_of_mode)
  );

endmodule
